// File: rtl/serial_rx.sv
// UART 8N1 receiver. The line is sampled at mid-bit using an integer
// clock-per-bit divider. Each received byte lands in a single-entry
// holding register, which is read through a valid/read handshake.
// Framing and overrun errors are reported through sticky flags.
module serial_rx #(
  parameter int CLK_FREQ  = 48_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  input  logic       i_rd,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_frame_err,
  output logic       o_overrun
);

  // Clocks per bit. The formula matches the one used by the transmitter.
  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  localparam logic [CW-1:0] RELOAD_FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] RELOAD_HALF = CW'(BAUD_DIV / 2 - 1);

  // Below 4 clocks per bit, the mid-bit sample cannot be aligned reliably.
  if (BAUD_DIV < 4) begin : g_bad_div
    $error("serial_rx: BAUD_DIV = CLK_FREQ / BAUD_RATE must be >= 4");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t        state;
  logic          rx_m;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  // Two-flop synchronizer. Both flops reset to the idle-high line level.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_rx;
      rx_s <= rx_m;
    end
  end

  // Receive FSM, bit timer and holding register.
  // A read clears the flags first, so any set later in this block wins over it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      o_valid     <= 1'b0;
      o_data      <= 8'h00;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      if (i_rd) begin
        o_valid     <= 1'b0;
        o_frame_err <= 1'b0;
        o_overrun   <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= RELOAD_HALF;
            state <= START;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              cnt     <= RELOAD_FULL;
              bit_idx <= '0;
              state   <= DATA;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shreg <= {rx_s, shreg[7:1]};
            cnt   <= RELOAD_FULL;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        STOP: begin
          if (cnt == '0) begin
            if (rx_s) begin
              o_data  <= shreg;
              o_valid <= 1'b1;
              if (o_valid && !i_rd) begin
                o_overrun <= 1'b1;
              end
              state <= IDLE;
            end else begin
              o_frame_err <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx at 4 clocks per bit. A behavioural
// transmitter drives the line. Checks use a vector table, hand-written
// corner sequences, and a queue-based scoreboard for back-to-back frames.
module tb_serial_rx;

  localparam int CLK_FREQ  = 500_000;
  localparam int BAUD_RATE = 115_200;
  localparam int DIV       = CLK_FREQ / BAUD_RATE;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       rd_man;
  logic       rd_auto;
  logic       rd;
  logic       valid;
  logic [7:0] data;
  logic       ferr;
  logic       ovr;

  int errors = 0;
  int checks = 0;
  bit auto_en = 1'b0;
  logic [7:0] sb_q[$];

  assign rd = rd_man | rd_auto;

  always #5 clk = ~clk;

  serial_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx), .i_rd(rd),
    .o_valid(valid), .o_data(data), .o_frame_err(ferr), .o_overrun(ovr)
  );

  typedef struct {
    logic [7:0] din;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame. Call this 1 time unit after a rising edge. It returns
  // at the same offset 10 bit times later, unless the stop bit is bad: in
  // that case the line is held low for 3 more bit times and then released.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(DIV);
    end
    rx = stop;
    tick(DIV);
    if (!stop) begin
      tick(3 * DIV);
      rx = 1'b1;
    end
  endtask

  task automatic pulse_rd();
    rd_man = 1'b1;
    tick(1);
    rd_man = 1'b0;
  endtask

  // Consumer for the scoreboard phase: reads every byte as soon as it is valid.
  initial begin
    rd_auto = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_en && valid && !rd_auto) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got %h expected none", data);
        end else begin
          chk("sb_data", data, sb_q.pop_front());
        end
        rd_auto = 1'b1;
      end else begin
        rd_auto = 1'b0;
      end
    end
  end

  initial begin
    int waited;
    rst_n  = 1'b0;
    rx     = 1'b1;
    rd_man = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 8'h00);
    chk("rst_ferr", ferr, 0);
    chk("rst_ovr", ovr, 0);

    // Vector table: single frames, each read out afterwards.
    vecs[0] = '{8'h4B, 1'b1, 1'b1, 8'h4B, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    vecs[3] = '{8'hA5, 1'b0, 1'b0, 8'hFF, 1'b1};
    vecs[4] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0};
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].din, vecs[v].stop);
      tick(1);
      chk($sformatf("vec%0d_valid", v), valid, vecs[v].exp_valid);
      chk($sformatf("vec%0d_data", v), data, vecs[v].exp_data);
      chk($sformatf("vec%0d_ferr", v), ferr, vecs[v].exp_ferr);
      chk($sformatf("vec%0d_ovr", v), ovr, 0);
      pulse_rd();
      chk($sformatf("vec%0d_rd_valid", v), valid, 0);
      chk($sformatf("vec%0d_rd_ferr", v), ferr, 0);
      tick(DIV);
    end

    // Glitch: a one-cycle low pulse must not start a reception.
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(12 * DIV);
    chk("glitch_valid", valid, 0);
    chk("glitch_ferr", ferr, 0);

    // A read in the same cycle as a frame error: the flag still ends up set.
    fork
      send_frame(8'hA5, 1'b0);
      begin
        tick(10 * DIV);
        rd_man = 1'b1;
        tick(1);
        rd_man = 1'b0;
      end
    join
    tick(1);
    chk("ferr_rd_ferr", ferr, 1);
    chk("ferr_rd_valid", valid, 0);
    pulse_rd();
    tick(DIV);

    // Overrun: two unread bytes.
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(1);
    chk("ovr_data", data, 8'h22);
    chk("ovr_valid", valid, 1);
    chk("ovr_flag", ovr, 1);
    pulse_rd();
    chk("ovr_rd_valid", valid, 0);
    chk("ovr_rd_flag", ovr, 0);
    tick(DIV);

    // A read in the exact cycle the second byte loads.
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h33, 1'b1);
      begin
        tick(10 * DIV);
        rd_man = 1'b1;
        tick(1);
        rd_man = 1'b0;
      end
    join
    chk("simrd_valid", valid, 1);
    chk("simrd_data", data, 8'h33);
    chk("simrd_ovr", ovr, 0);
    pulse_rd();
    tick(DIV);

    // Reset mid-frame while the outputs hold a byte and an overrun.
    send_frame(8'h77, 1'b1);
    send_frame(8'h78, 1'b1);
    tick(1);
    chk("prerst_ovr", ovr, 1);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        tick(5 * DIV + 2);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("midrst_valid", valid, 0);
        chk("midrst_data", data, 8'h00);
        chk("midrst_ovr", ovr, 0);
        chk("midrst_ferr", ferr, 0);
      end
    join
    tick(DIV);
    send_frame(8'h5A, 1'b1);
    tick(1);
    chk("postrst_valid", valid, 1);
    chk("postrst_data", data, 8'h5A);
    chk("postrst_ferr", ferr, 0);
    pulse_rd();
    tick(DIV);

    // Scoreboard: back-to-back frames, read as they arrive.
    auto_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [7:0] b;
      b = (i < 3) ? 8'h4B : ((i == 3) ? 8'h12 : ((i == 4) ? 8'h5A : 8'hC3));
      sb_q.push_back(b);
      send_frame(b, 1'b1);
    end
    waited = 0;
    while (sb_q.size() != 0 && waited < 200) begin
      tick(1);
      waited++;
    end
    tick(4);
    chk("sb_drained", 8'(sb_q.size()), 0);
    chk("sb_ovr", ovr, 0);
    chk("sb_ferr", ferr, 0);
    chk("sb_valid", valid, 0);
    auto_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
